// File: rtl/scr1_dmem_arb_if.sv
// Shared types and the scr1_memif-style bus used by the data-memory arbiter.
// The master side issues requests; the slave side accepts them and
// returns the response.
package scr1_dmem_arb_pkg;

   localparam int SCR1_DMEM_AWIDTH = 32;
   localparam int SCR1_DMEM_DWIDTH = 32;

   typedef enum logic {
      SCR1_MEM_CMD_RD = 1'b0,
      SCR1_MEM_CMD_WR = 1'b1
   } type_scr1_mem_cmd_e;

   typedef enum logic [1:0] {
      SCR1_MEM_WIDTH_BYTE  = 2'b00,
      SCR1_MEM_WIDTH_HWORD = 2'b01,
      SCR1_MEM_WIDTH_WORD  = 2'b10,
      SCR1_MEM_WIDTH_ERROR = 2'b11
   } type_scr1_mem_width_e;

   typedef enum logic [1:0] {
      SCR1_MEM_RESP_NOTRDY = 2'b00,
      SCR1_MEM_RESP_RDY_OK = 2'b01,
      SCR1_MEM_RESP_RDY_ER = 2'b10
   } type_scr1_mem_resp_e;

endpackage : scr1_dmem_arb_pkg

// Handshake: a request transfers in the cycle where req and req_ack are
// both high. The requester keeps req, cmd, width, addr and wdata stable
// until then (it may withdraw req to abort). The response arrives on a later
// cycle as resp != NOTRDY, with rdata valid alongside a read response.
interface scr1_dmem_arb_if;
   import scr1_dmem_arb_pkg::*;

   logic                          req;
   type_scr1_mem_cmd_e            cmd;
   type_scr1_mem_width_e          width;
   logic [SCR1_DMEM_AWIDTH-1:0]   addr;
   logic [SCR1_DMEM_DWIDTH-1:0]   wdata;
   logic                          req_ack;
   logic [SCR1_DMEM_DWIDTH-1:0]   rdata;
   type_scr1_mem_resp_e           resp;

   modport master (
      output req, cmd, width, addr, wdata,
      input  req_ack, rdata, resp
   );

   modport slave (
      input  req, cmd, width, addr, wdata,
      output req_ack, rdata, resp
   );

endinterface : scr1_dmem_arb_if

// File: rtl/scr1_dmem_arb.sv
// Round-robin arbiter sharing the core data-memory port between the LSU (p0)
// and a secondary master (p1). One transaction outstanding at a time; the
// response goes back to the owning port. A watchdog turns a lost response
// into an access fault and swallows the late response when it shows up.
module scr1_dmem_arb
   import scr1_dmem_arb_pkg::*;
#(
   parameter int unsigned TMO_CYCLES = 255
)(
   input  logic                   clk,
   input  logic                   rst_n,
   scr1_dmem_arb_if.slave         p0,
   scr1_dmem_arb_if.slave         p1,
   scr1_dmem_arb_if.master        dmem,
   output logic [1:0]             dbg_state
);

   localparam int unsigned CW = (TMO_CYCLES > 0) ? $clog2(TMO_CYCLES + 1) : 1;
   localparam int unsigned TMO_M1 = (TMO_CYCLES > 0) ? (TMO_CYCLES - 1) : 0;
   localparam logic [CW-1:0] TMO_LAST = CW'(TMO_M1);
   localparam bit TMO_EN = (TMO_CYCLES != 0);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic            owner_q, owner_d;
   logic            rr_last_q, rr_last_d;
   logic            lock_q, lock_d;
   logic            lock_sel_q, lock_sel_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic            req0, req1;
   logic            sel;
   logic            sel_req;
   logic            grant_req;
   logic            is_idle, is_busy;
   logic            resp_valid;
   logic            timeout;
   type_scr1_mem_resp_e resp_fwd;

   // Requests are masked while reset is held so every output shows its
   // reset value immediately, regardless of what the requesters drive.
   assign req0 = p0.req & rst_n;
   assign req1 = p1.req & rst_n;

   assign is_idle    = (state_q == ST_IDLE);
   assign is_busy    = (state_q == ST_BUSY);
   assign resp_valid = (dmem.resp != SCR1_MEM_RESP_NOTRDY);
   assign timeout    = TMO_EN && is_busy && !resp_valid && (cnt_q == TMO_LAST);
   assign dbg_state  = state_q;

   // Port selection: a held grant wins, then a lone requester, then the
   // port that was not granted last.
   always_comb begin
      sel = 1'b0;
      if (lock_q) begin
         sel = lock_sel_q;
      end else if (req0 && !req1) begin
         sel = 1'b0;
      end else if (req1 && !req0) begin
         sel = 1'b1;
      end else if (req0 && req1) begin
         sel = ~rr_last_q;
      end
   end

   assign sel_req   = sel ? req1 : req0;
   assign grant_req = is_idle & sel_req;

   // Request path: memory sees the selected port; only that port gets the ack.
   always_comb begin
      dmem.req   = grant_req;
      dmem.cmd   = sel ? p1.cmd   : p0.cmd;
      dmem.width = sel ? p1.width : p0.width;
      dmem.addr  = sel ? p1.addr  : p0.addr;
      dmem.wdata = sel ? p1.wdata : p0.wdata;
      p0.req_ack = grant_req & ~sel & dmem.req_ack;
      p1.req_ack = grant_req &  sel & dmem.req_ack;
   end

   // Response path: only the owner sees the response, and only while BUSY;
   // on watchdog expiry the owner gets an access fault instead.
   always_comb begin
      resp_fwd = timeout ? SCR1_MEM_RESP_RDY_ER : dmem.resp;
      p0.resp  = (is_busy && !owner_q) ? resp_fwd : SCR1_MEM_RESP_NOTRDY;
      p1.resp  = (is_busy &&  owner_q) ? resp_fwd : SCR1_MEM_RESP_NOTRDY;
      p0.rdata = dmem.rdata;
      p1.rdata = dmem.rdata;
   end

   // Next-state: grant hold, handshake bookkeeping and the watchdog.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      rr_last_d  = rr_last_q;
      lock_d     = lock_q;
      lock_sel_d = lock_sel_q;
      cnt_d      = cnt_q;
      case (state_q)
         ST_IDLE: begin
            // Hold the grant only while the selected request sits unacked;
            // a handshake or a withdrawn request both release it.
            lock_d = grant_req & ~dmem.req_ack;
            if (grant_req && !dmem.req_ack) begin
               lock_sel_d = sel;
            end
            if (grant_req && dmem.req_ack) begin
               owner_d   = sel;
               rr_last_d = sel;
               cnt_d     = '0;
               state_d   = ST_BUSY;
            end
         end
         ST_BUSY: begin
            // A real response beats a watchdog expiry in the same cycle.
            if (resp_valid) begin
               state_d = ST_IDLE;
            end else if (timeout) begin
               state_d = ST_DRAIN;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_DRAIN: begin
            if (resp_valid) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and control registers, asynchronously reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         owner_q    <= 1'b0;
         rr_last_q  <= 1'b1;
         lock_q     <= 1'b0;
         lock_sel_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         rr_last_q  <= rr_last_d;
         lock_q     <= lock_d;
         lock_sel_q <= lock_sel_d;
         cnt_q      <= cnt_d;
      end
   end

endmodule : scr1_dmem_arb

// File: tb/tb_scr1_dmem_arb.sv
// Bench for scr1_dmem_arb: directed vector table, hand-written multi-cycle
// sequences (watchdog, reset in flight) and randomized traffic against a
// transaction-level reference model.
module tb_scr1_dmem_arb;
  import scr1_dmem_arb_pkg::*;

  localparam int TMO = 4;
  localparam type_scr1_mem_resp_e RN = SCR1_MEM_RESP_NOTRDY;
  localparam type_scr1_mem_resp_e RO = SCR1_MEM_RESP_RDY_OK;
  localparam type_scr1_mem_resp_e RE = SCR1_MEM_RESP_RDY_ER;

  logic clk;
  logic rst_n;
  logic [1:0] dbg_state;

  scr1_dmem_arb_if p0_bus ();
  scr1_dmem_arb_if p1_bus ();
  scr1_dmem_arb_if dmem_bus ();

  scr1_dmem_arb #(.TMO_CYCLES(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .p0        (p0_bus.slave),
    .p1        (p1_bus.slave),
    .dmem      (dmem_bus.master),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    bit r0;
    bit r1;
    bit ack;
    type_scr1_mem_resp_e rsp;
    bit e_req;
    bit e_a0;
    bit e_a1;
    type_scr1_mem_resp_e e_rs0;
    type_scr1_mem_resp_e e_rs1;
    logic [31:0] e_addr;
  } vec_t;

  vec_t tbl[20];

  // scoreboard of expected grants for the random phase
  logic [1:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r0, input bit r1, input bit ack, input type_scr1_mem_resp_e rsp);
    p0_bus.req = r0;
    p1_bus.req = r1;
    dmem_bus.req_ack = ack;
    dmem_bus.resp = rsp;
  endtask

  // drive one cycle, check at the falling edge, advance past the rising edge
  task automatic step(input string nm, input bit r0, input bit r1, input bit ack,
                      input type_scr1_mem_resp_e rsp, input bit e_req, input bit e_a0,
                      input bit e_a1, input type_scr1_mem_resp_e e_rs0,
                      input type_scr1_mem_resp_e e_rs1, input logic [31:0] e_addr);
    drive(r0, r1, ack, rsp);
    @(negedge clk);
    chk({nm, ".dmem_req"}, 32'(dmem_bus.req), 32'(e_req));
    chk({nm, ".p0_ack"}, 32'(p0_bus.req_ack), 32'(e_a0));
    chk({nm, ".p1_ack"}, 32'(p1_bus.req_ack), 32'(e_a1));
    chk({nm, ".p0_resp"}, 32'(p0_bus.resp), 32'(e_rs0));
    chk({nm, ".p1_resp"}, 32'(p1_bus.resp), 32'(e_rs1));
    if (e_req) chk({nm, ".dmem_addr"}, dmem_bus.addr, e_addr);
    @(posedge clk);
    #1;
  endtask

  task automatic set_fixed_ports();
    p0_bus.addr = 32'h100; p0_bus.cmd = SCR1_MEM_CMD_RD;
    p0_bus.width = SCR1_MEM_WIDTH_WORD; p0_bus.wdata = 32'h0;
    p1_bus.addr = 32'h200; p1_bus.cmd = SCR1_MEM_CMD_WR;
    p1_bus.width = SCR1_MEM_WIDTH_WORD; p1_bus.wdata = 32'h1234_5678;
    dmem_bus.rdata = 32'hDEAD_BEEF;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // model state for the random phase
    bit m_busy;
    bit m_late;
    int m_owner;
    int m_age;
    int m_last;
    int m_hold;
    bit rr[2];
    bit ack;
    type_scr1_mem_resp_e rsp;
    bit e_req;
    bit e_a[2];
    type_scr1_mem_resp_e e_rs[2];
    int pick;
    bit model_idle;
    logic [31:0] pa[2];
    logic [31:0] pw[2];
    type_scr1_mem_cmd_e pc[2];
    type_scr1_mem_width_e pwd[2];
    logic [1:0] got;
    int grants_seen;

    tbl[0]  = '{1,0,1,RN, 1,1,0,RN,RN,32'h100};
    tbl[1]  = '{0,0,0,RO, 0,0,0,RO,RN,32'h0};
    tbl[2]  = '{1,1,1,RN, 1,0,1,RN,RN,32'h200};
    tbl[3]  = '{1,1,1,RO, 0,0,0,RN,RO,32'h0};
    tbl[4]  = '{1,1,1,RN, 1,1,0,RN,RN,32'h100};
    tbl[5]  = '{1,1,1,RO, 0,0,0,RO,RN,32'h0};
    tbl[6]  = '{1,1,1,RN, 1,0,1,RN,RN,32'h200};
    tbl[7]  = '{0,0,0,RE, 0,0,0,RN,RE,32'h0};
    tbl[8]  = '{0,1,0,RN, 1,0,0,RN,RN,32'h200};
    tbl[9]  = '{1,1,0,RN, 1,0,0,RN,RN,32'h200};
    tbl[10] = '{1,1,0,RN, 1,0,0,RN,RN,32'h200};
    tbl[11] = '{1,1,1,RN, 1,0,1,RN,RN,32'h200};
    tbl[12] = '{1,0,1,RO, 0,0,0,RN,RO,32'h0};
    tbl[13] = '{1,0,1,RN, 1,1,0,RN,RN,32'h100};
    tbl[14] = '{0,0,0,RO, 0,0,0,RO,RN,32'h0};
    tbl[15] = '{1,0,0,RN, 1,0,0,RN,RN,32'h100};
    tbl[16] = '{0,1,0,RN, 0,0,0,RN,RN,32'h0};
    tbl[17] = '{0,1,1,RN, 1,0,1,RN,RN,32'h200};
    tbl[18] = '{0,0,0,RO, 0,0,0,RN,RO,32'h0};
    tbl[19] = '{0,0,0,RO, 0,0,0,RN,RN,32'h0};

    // reset values, with p1 requesting to show the mux still reads port 0
    set_fixed_ports();
    drive(0, 1, 1, RO);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst.dmem_req", 32'(dmem_bus.req), 32'd0);
    chk("rst.p0_ack", 32'(p0_bus.req_ack), 32'd0);
    chk("rst.p1_ack", 32'(p1_bus.req_ack), 32'd0);
    chk("rst.p0_resp", 32'(p0_bus.resp), 32'(RN));
    chk("rst.p1_resp", 32'(p1_bus.resp), 32'(RN));
    chk("rst.dmem_addr", dmem_bus.addr, 32'h100);
    chk("rst.dmem_cmd", 32'(dmem_bus.cmd), 32'(SCR1_MEM_CMD_RD));
    chk("rst.p0_rdata", p0_bus.rdata, 32'hDEAD_BEEF);
    chk("rst.p1_rdata", p1_bus.rdata, 32'hDEAD_BEEF);
    drive(0, 0, 0, RN);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // directed vector table
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].r0, tbl[i].r1, tbl[i].ack, tbl[i].rsp);
      @(negedge clk);
      chk($sformatf("tbl%0d.dmem_req", i), 32'(dmem_bus.req), 32'(tbl[i].e_req));
      chk($sformatf("tbl%0d.p0_ack", i), 32'(p0_bus.req_ack), 32'(tbl[i].e_a0));
      chk($sformatf("tbl%0d.p1_ack", i), 32'(p1_bus.req_ack), 32'(tbl[i].e_a1));
      chk($sformatf("tbl%0d.p0_resp", i), 32'(p0_bus.resp), 32'(tbl[i].e_rs0));
      chk($sformatf("tbl%0d.p1_resp", i), 32'(p1_bus.resp), 32'(tbl[i].e_rs1));
      if (tbl[i].e_req) chk($sformatf("tbl%0d.dmem_addr", i), dmem_bus.addr, tbl[i].e_addr);
      if (tbl[i].e_rs0 != RN) chk($sformatf("tbl%0d.p0_rdata", i), p0_bus.rdata, 32'hDEAD_BEEF);
      @(posedge clk);
      #1;
    end

    // watchdog expiry: fault in the 4th busy cycle, late response swallowed
    step("wd.hs",  1,0,1,RN, 1,1,0,RN,RN,32'h100);
    step("wd.b1",  0,0,0,RN, 0,0,0,RN,RN,32'h0);
    step("wd.b2",  0,0,0,RN, 0,0,0,RN,RN,32'h0);
    step("wd.b3",  0,0,0,RN, 0,0,0,RN,RN,32'h0);
    step("wd.b4",  0,0,0,RN, 0,0,0,RE,RN,32'h0);
    step("wd.d1",  0,1,1,RN, 0,0,0,RN,RN,32'h0);
    step("wd.d2",  0,1,1,RO, 0,0,0,RN,RN,32'h0);
    step("wd.p1g", 0,1,1,RN, 1,0,1,RN,RN,32'h200);
    step("wd.p1r", 0,0,0,RO, 0,0,0,RN,RO,32'h0);

    // response on the expiry cycle wins over the timeout
    step("edge.hs",  1,0,1,RN, 1,1,0,RN,RN,32'h100);
    step("edge.b1",  0,0,0,RN, 0,0,0,RN,RN,32'h0);
    step("edge.b2",  0,0,0,RN, 0,0,0,RN,RN,32'h0);
    step("edge.b3",  0,0,0,RN, 0,0,0,RN,RN,32'h0);
    step("edge.b4",  0,0,0,RO, 0,0,0,RO,RN,32'h0);
    step("edge.p1g", 0,1,1,RN, 1,0,1,RN,RN,32'h200);
    step("edge.p1r", 0,0,0,RO, 0,0,0,RN,RO,32'h0);

    // reset in BUSY: outputs fall to reset values at once
    step("rb.hs", 1,0,1,RN, 1,1,0,RN,RN,32'h100);
    drive(1, 0, 1, RO);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rb.dmem_req", 32'(dmem_bus.req), 32'd0);
    chk("rb.p0_ack", 32'(p0_bus.req_ack), 32'd0);
    chk("rb.p0_resp", 32'(p0_bus.resp), 32'(RN));
    chk("rb.p1_resp", 32'(p1_bus.resp), 32'(RN));
    chk("rb.dmem_addr", dmem_bus.addr, 32'h100);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("rb.stray", 0,0,0,RO, 0,0,0,RN,RN,32'h0);
    step("rb.tie",   1,1,1,RN, 1,1,0,RN,RN,32'h100);
    step("rb.resp",  0,0,0,RO, 0,0,0,RO,RN,32'h0);

    // randomized traffic against a transaction-level model
    drive(0, 0, 0, RN);
    do_reset();
    m_busy = 0; m_late = 0; m_owner = 0; m_age = 0; m_last = 1; m_hold = -1;
    grants_seen = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 2; p++) begin
        rr[p] = 1'($urandom_range(0, 1));
        pa[p] = $urandom;
        pw[p] = $urandom;
        pc[p] = ($urandom_range(0, 1) == 0) ? SCR1_MEM_CMD_RD : SCR1_MEM_CMD_WR;
        case ($urandom_range(0, 2))
          0: pwd[p] = SCR1_MEM_WIDTH_BYTE;
          1: pwd[p] = SCR1_MEM_WIDTH_HWORD;
          default: pwd[p] = SCR1_MEM_WIDTH_WORD;
        endcase
      end
      ack = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        6, 7, 8: rsp = RO;
        9: rsp = RE;
        default: rsp = RN;
      endcase
      p0_bus.addr = pa[0]; p0_bus.wdata = pw[0]; p0_bus.cmd = pc[0]; p0_bus.width = pwd[0];
      p1_bus.addr = pa[1]; p1_bus.wdata = pw[1]; p1_bus.cmd = pc[1]; p1_bus.width = pwd[1];
      dmem_bus.rdata = $urandom;
      drive(rr[0], rr[1], ack, rsp);

      // expected behaviour for this cycle
      e_req = 0; e_a[0] = 0; e_a[1] = 0; e_rs[0] = RN; e_rs[1] = RN;
      model_idle = 0; pick = 0;
      if (m_busy) begin
        if (rsp != RN) begin
          e_rs[m_owner] = rsp;
          m_busy = 0;
        end else if (m_age == TMO - 1) begin
          e_rs[m_owner] = RE;
          m_busy = 0;
          m_late = 1;
        end else begin
          m_age++;
        end
      end else if (m_late) begin
        if (rsp != RN) m_late = 0;
      end else begin
        model_idle = 1;
        if (m_hold >= 0) pick = m_hold;
        else if (rr[0] && rr[1]) pick = 1 - m_last;
        else if (rr[1]) pick = 1;
        else pick = 0;
        e_req = rr[pick];
        if (e_req && ack) begin
          e_a[pick] = 1;
          m_busy = 1; m_owner = pick; m_age = 0; m_last = pick; m_hold = -1;
          exp_q.push_back(2'(pick));
        end else begin
          m_hold = e_req ? pick : -1;
        end
      end

      @(negedge clk);
      chk("rnd.dmem_req", 32'(dmem_bus.req), 32'(e_req));
      chk("rnd.p0_ack", 32'(p0_bus.req_ack), 32'(e_a[0]));
      chk("rnd.p1_ack", 32'(p1_bus.req_ack), 32'(e_a[1]));
      chk("rnd.p0_resp", 32'(p0_bus.resp), 32'(e_rs[0]));
      chk("rnd.p1_resp", 32'(p1_bus.resp), 32'(e_rs[1]));
      chk("rnd.p1_rdata", p1_bus.rdata, dmem_bus.rdata);
      if (model_idle && e_req) begin
        chk("rnd.dmem_addr", dmem_bus.addr, pa[pick]);
        chk("rnd.dmem_wdata", dmem_bus.wdata, pw[pick]);
        chk("rnd.dmem_cmd", 32'(dmem_bus.cmd), 32'(pc[pick]));
        chk("rnd.dmem_width", 32'(dmem_bus.width), 32'(pwd[pick]));
      end
      // grants observed on the acks are matched in order against the model
      if (p0_bus.req_ack || p1_bus.req_ack) begin
        got = p1_bus.req_ack ? 2'd1 : 2'd0;
        if (exp_q.size() == 0) begin
          chk("rnd.grant_unexpected", 32'(got), 32'd3);
        end else begin
          chk("rnd.grant_order", 32'(got), 32'(exp_q.pop_front()));
          grants_seen++;
        end
      end
      @(posedge clk);
      #1;
    end
    chk("rnd.grants_left", 32'(exp_q.size()), 32'd0);
    if (grants_seen < 100) chk("rnd.grant_activity", 32'(grants_seen), 32'd100);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_scr1_dmem_arb

// File: doc/scr1_dmem_arb.md
# scr1_dmem_arb

Two-requester arbiter that shares the single core data-memory port (scr1_memif protocol) between the pipeline LSU (port 0) and a secondary master such as the debug/system-bus access unit (port 1). Only one transaction is outstanding at a time. Requesters are granted round-robin. The grant is held while a request waits for acknowledge. Each response is routed back to the owning port. A response watchdog converts a lost response into an access-fault response and discards the late response when it arrives.

## Interface
- TMO_CYCLES, 255: response watchdog limit in BUSY cycles; 0 disables the watchdog.
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- p0_req / p1_req  in  1  request from port 0 / port 1
- p0_cmd / p1_cmd  in  type_scr1_mem_cmd_e  RD/WR
- p0_width / p1_width  in  type_scr1_mem_width_e  BYTE/HWORD/WORD
- p0_addr / p1_addr  in  SCR1_DMEM_AWIDTH  address
- p0_wdata / p1_wdata  in  SCR1_DMEM_DWIDTH  store data
- p0_req_ack / p1_req_ack  out  1  request accepted
- p0_rdata / p1_rdata  out  SCR1_DMEM_DWIDTH  read data (dmem_rdata fanned out unchanged)
- p0_resp / p1_resp  out  type_scr1_mem_resp_e  NOTRDY/RDY_OK/RDY_ER
- dmem_req  out  1  request to memory
- dmem_cmd, dmem_width, dmem_addr, dmem_wdata  out  as above  muxed from the selected port
- dmem_req_ack  in  1  memory accepted request
- dmem_rdata  in  SCR1_DMEM_DWIDTH  read data
- dmem_resp  in  type_scr1_mem_resp_e  memory response

## Operation
- State machine states:
  - IDLE: accepts requests.
  - BUSY: one transaction is outstanding.
  - DRAIN: waits for and discards a late response after a timeout.
- Registers:
  - owner (1b): port that owns the outstanding transaction.
  - rr_last (1b): last port granted; resets to 1, so port 0 wins the first tie.
  - lock / lock_sel: grant hold flag and the port it holds.
  - cnt: watchdog counter, width clog2(TMO_CYCLES+1).
- Select in IDLE:
  - If lock is set: sel = lock_sel.
  - Otherwise, if only one port requests: sel = that port.
  - Otherwise, if both ports request: sel = ~rr_last.
- IDLE outputs:
  - dmem_req = selected port's req.
  - dmem_cmd/width/addr/wdata come from sel; when no port requests, sel = 0.
  - p<sel>_req_ack = dmem_req_ack & p<sel>_req. The other port's ack = 0.
- Lock rules:
  - dmem_req & ~dmem_req_ack in IDLE: lock <= 1, lock_sel <= sel.
  - Handshake (dmem_req & dmem_req_ack): lock <= 0.
  - Selected req withdrawn while unacked: lock <= 0 (requester aborted).
- Handshake: owner <= sel, rr_last <= sel, cnt <= 0, state -> BUSY.
- In BUSY and DRAIN, dmem_req = 0 and both acks = 0. Requests wait.
- BUSY:
  - p<owner>_resp = dmem_resp. The other port's resp = NOTRDY.
  - dmem_resp RDY_OK or RDY_ER -> IDLE.
  - Timeout: TMO_CYCLES≠0, dmem_resp = NOTRDY and cnt == TMO_CYCLES-1. That cycle p<owner>_resp = RDY_ER; state -> DRAIN.
  - No response and no timeout: cnt <= cnt+1.
- DRAIN:
  - Both resp = NOTRDY.
  - dmem_resp ≠ NOTRDY -> IDLE; the response is discarded.
- In IDLE, both resp = NOTRDY regardless of dmem_resp. A stray response is ignored.

## Timing
- Reset values:
  - state IDLE, owner 0, rr_last 1, lock 0, cnt 0.
  - dmem_req 0, both acks 0, both resp NOTRDY.
  - dmem_cmd/width/addr/wdata show port 0 inputs.
  - rdata follows dmem_rdata.
- Latency:
  - Request to memory and ack back: 0 cycles, combinational in IDLE.
  - Response to owner: 0 cycles, combinational in BUSY.
- Minimum transaction is 2 cycles: handshake cycle, then response cycle. The next request is granted the cycle after the response.
- A response in the same cycle the watchdog would expire is delivered normally; it has priority over the timeout.
- rst_n assertion mid-BUSY or mid-DRAIN returns to IDLE immediately. The in-flight response is not forwarded.

## Test plan
- Single request: p0 LW addr 0x100, ack same cycle, RDY_OK next cycle with rdata 0xDEADBEEF.
  - p0_resp = RDY_OK and p0_rdata = 0xDEADBEEF in cycle 2.
  - p1_resp = NOTRDY throughout.
- Tie after reset: p0 and p1 request together with constant ack, and each response arrives 1 cycle after ack.
  - Grants go p0, p1, p0, p1.
  - Each ack is followed by a response in the next cycle.
- Lock: p0 requests, dmem_req_ack held low for 3 cycles; p1 requests in cycle 2.
  - dmem_addr stays on p0 until ack.
  - p1 is granted after p0's response.
- Error routing: p1 SW, memory returns RDY_ER.
  - p1_resp = RDY_ER for 1 cycle; p0_resp = NOTRDY.
- Watchdog: TMO_CYCLES=4, p0 handshake, no response.
  - p0_resp = RDY_ER in the 4th cycle after the handshake, then DRAIN.
  - A late RDY_OK 2 cycles later is discarded; both resp stay NOTRDY.
  - IDLE resumes and p1 is then granted.
- Reset in BUSY: assert rst_n low in the cycle after the handshake.
  - All outputs take reset values immediately.
  - A response arriving after reset is ignored.
